// File: rtl/mix_columns_seq.sv
// -----------------------------------------------------------------------------
// mix_columns_seq
//
// Forward AES MixColumns engine for the encryption datapath. A 128-bit state
// is accepted over a valid/ready handshake, transformed in place a group of
// COLS_PER_CYCLE columns per clock, and presented on a held valid/ready
// output. A per-transaction bypass flag skips the transform for the final
// AES round, which has no MixColumns step.
//
// Parameters
//   COLS_PER_CYCLE : columns transformed per BUSY cycle (1, 2 or 4)
//
// Ports
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous active-high reset
//   in_valid   in   1    input state valid
//   in_ready   out  1    block can accept a state (FSM in IDLE)
//   in_state   in   128  state; column c = bits [127-32c -: 32],
//                        byte 0 of a column in its MSBs
//   in_bypass  in   1    sampled with in_state; 1 = skip MixColumns
//   out_valid  out  1    result valid (FSM in DONE)
//   out_ready  in   1    downstream accepts result
//   out_state  out  128  transformed state, same packing as in_state
//   busy       out  1    high in BUSY or DONE
//
// Handshake rules (both ports): a transfer happens on a rising edge where
// valid and ready are both high. A producer holding valid keeps its data
// stable until the transfer; ready never depends combinationally on valid.
// Here in_ready and out_valid are pure decodes of the registered FSM state.
// -----------------------------------------------------------------------------
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  // ---------------------------------------------------------------------------
  // Parameter legality: only groupings that tile the four columns exactly.
  // ---------------------------------------------------------------------------
  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4))
  begin : g_bad_cols_per_cycle
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Group width held in 3 bits so col_cnt + STEP can reach 4 without wrapping.
  localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

  // ---------------------------------------------------------------------------
  // FSM encoding
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e       state_q;
  state_e       state_d;
  logic [1:0]   col_cnt_q;
  logic [1:0]   col_cnt_d;
  logic [127:0] data_q;
  logic [127:0] data_d;

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers, reduction polynomial 0x11B.
  // ---------------------------------------------------------------------------
  // Multiply by 2: shift left, fold the dropped MSB back in as 0x1B.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by 3 as 2x ^ x.
  function automatic logic [7:0] mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  // One column: a0 (MSB byte) .. a3 (LSB byte) -> b0 .. b3.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ mul3(a1)  ^ a2         ^ a3;
    b1 = a0        ^ xtime(a1) ^ mul3(a2)   ^ a3;
    b2 = a0        ^ a1        ^ xtime(a2)  ^ mul3(a3);
    b3 = mul3(a0)  ^ a1        ^ a2         ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  // ---------------------------------------------------------------------------
  // Column datapath. All four column results are formed from the working
  // register; the select mask below decides which ones are written back, so
  // columns outside the current group keep their present contents.
  // ---------------------------------------------------------------------------
  logic [127:0] mixed_all;

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign mixed_all[127-32*c -: 32] = mix_column(data_q[127-32*c -: 32]);
  end

  logic [2:0] cnt_next;
  logic [3:0] col_sel;

  assign cnt_next = {1'b0, col_cnt_q} + STEP;

  always_comb begin
    col_sel = '0;
    for (int c = 0; c < 4; c++) begin
      col_sel[c] = (3'(c) >= {1'b0, col_cnt_q}) && (3'(c) < cnt_next);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state register and working register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      col_cnt_q <= 2'd0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      data_q    <= data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    data_d    = data_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d    = in_state;
          col_cnt_d = 2'd0;
          // Bypass is resolved at capture: the state goes straight to DONE
          // untouched, so the flag itself never needs to be stored.
          state_d   = in_bypass ? S_DONE : S_BUSY;
        end
      end

      S_BUSY: begin
        for (int c = 0; c < 4; c++) begin
          if (col_sel[c]) begin
            data_d[127-32*c -: 32] = mixed_all[127-32*c -: 32];
          end
        end
        if (cnt_next == 3'd4) begin
          state_d   = S_DONE;
          col_cnt_d = 2'd0;
        end else begin
          col_cnt_d = cnt_next[1:0];
        end
      end

      S_DONE: begin
        // in_ready is low here, so a same-cycle in_valid is left pending and
        // is picked up from IDLE on the following edge.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        col_cnt_d = 2'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only
  // ---------------------------------------------------------------------------
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_BUSY) || (state_q == S_DONE);
  assign out_state = data_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// -----------------------------------------------------------------------------
// tb_mix_columns_seq
//
// Bench for mix_columns_seq. Three instances (COLS_PER_CYCLE = 1, 2, 4) share
// clock, reset, in_state, in_bypass and out_ready; each has its own in_valid
// so only the instance under test ever captures. Expected results are pushed
// when a state is offered and popped by a negedge monitor on the active
// instance when its output handshake completes.
// -----------------------------------------------------------------------------
module tb_mix_columns_seq;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [2:0]   in_valid_v;
  logic [2:0]   in_ready_v;
  logic [127:0] in_state;
  logic         in_bypass;
  logic [2:0]   out_valid_v;
  logic         out_ready;
  logic [127:0] out_state_a [3];
  logic [2:0]   busy_v;

  int unsigned  n_vec = 0;
  int unsigned  n_err = 0;
  int           act   = 0;

  logic [127:0] exp_q[$];

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] KNOWN_IN  = 128'hdb135345_f20a225c_01010101_80000000;
  localparam logic [127:0] KNOWN_OUT = 128'h8e4da1bc_9fdc589d_01010101_1b80809b;
  localparam logic [127:0] BYP_IN   = 128'h00112233_44556677_8899aabb_ccddeeff;

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_state(in_state), .in_bypass(in_bypass),
    .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .out_state(out_state_a[0]), .busy(busy_v[0])
  );

  mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_state(in_state), .in_bypass(in_bypass),
    .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .out_state(out_state_a[1]), .busy(busy_v[1])
  );

  mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_state(in_state), .in_bypass(in_bypass),
    .out_valid(out_valid_v[2]), .out_ready(out_ready),
    .out_state(out_state_a[2]), .busy(busy_v[2])
  );

  // ---------------------------------------------------------------------------
  // Reference model: generic shift-and-add GF(2^8) multiply
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [8:0] t;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      t = {x, 1'b0};
      if (t[8]) t = t ^ 9'h11b;
      x = t[7:0];
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_ref(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a [4];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
      r[127 - 32*c      -: 8] = gmul(a[0], 8'd2) ^ gmul(a[1], 8'd3) ^ a[2] ^ a[3];
      r[127 - 32*c - 8  -: 8] = a[0] ^ gmul(a[1], 8'd2) ^ gmul(a[2], 8'd3) ^ a[3];
      r[127 - 32*c - 16 -: 8] = a[0] ^ a[1] ^ gmul(a[2], 8'd2) ^ gmul(a[3], 8'd3);
      r[127 - 32*c - 24 -: 8] = gmul(a[0], 8'd3) ^ a[1] ^ a[2] ^ gmul(a[3], 8'd2);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one state to instance idx; returns just after the capture edge.
  task automatic send(input int idx, input logic [127:0] st, input logic byp,
                      input logic [127:0] exp, input bit hold);
    int guard;
    guard         = 0;
    in_state      = st;
    in_bypass     = byp;
    in_valid_v[idx] = 1'b1;
    while (!in_ready_v[idx] && guard < 64) begin
      tick();
      guard++;
    end
    if (!in_ready_v[idx]) begin
      check("accept_timeout", 128'(0), 128'(1));
      in_valid_v[idx] = 1'b0;
      return;
    end
    exp_q.push_back(exp);
    tick();
    if (!hold) in_valid_v[idx] = 1'b0;
  endtask

  // Count edges from the capture edge until out_valid rises.
  task automatic wait_out(input int idx, input int exp_lat);
    int cnt;
    cnt = 0;
    while (!out_valid_v[idx] && cnt < 64) begin
      tick();
      cnt++;
    end
    check($sformatf("latency_cpc%0d", 1 << idx), 128'(cnt), 128'(exp_lat));
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      tick();
      g++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 128'(exp_q.size()), 128'(0));
      exp_q.delete();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst && out_valid_v[act] && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", 128'(1), 128'(0));
      else                   check("out_state", out_state_a[act], exp_q.pop_front());
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int           cnt;
    int           g;
    logic [127:0] st;

    rst        = 1'b1;
    in_valid_v = 3'b000;
    in_state   = '0;
    in_bypass  = 1'b0;
    out_ready  = 1'b1;
    repeat (2) tick();

    // Reset state of every instance
    for (int i = 0; i < 3; i++) begin
      check("rst_out_valid", 128'(out_valid_v[i]), 128'(0));
      check("rst_in_ready",  128'(in_ready_v[i]),  128'(1));
      check("rst_busy",      128'(busy_v[i]),      128'(0));
      check("rst_out_state", out_state_a[i],       128'(0));
    end
    rst = 1'b0;
    tick();

    // FIPS round-1 vector and xtime boundary on every grouping
    for (int i = 0; i < 3; i++) begin
      act = i;
      send(i, FIPS_IN, 1'b0, FIPS_OUT, 1'b0);
      wait_out(i, 4 >> i);
      drain();
      send(i, KNOWN_IN, 1'b0, KNOWN_OUT, 1'b0);
      wait_out(i, 4 >> i);
      drain();
    end
    act = 0;
    tick();

    // Bypass: result on the capture edge, busy for one cycle
    send(0, BYP_IN, 1'b1, BYP_IN, 1'b0);
    wait_out(0, 0);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy_v[0]) cnt++;
    end
    check("bypass_busy_cycles", 128'(cnt), 128'(1));
    drain();
    tick();

    // Backpressure, with in_valid pulses and in_state changes after capture
    out_ready = 1'b0;
    send(0, FIPS_IN, 1'b0, FIPS_OUT, 1'b0);
    in_valid_v[0] = 1'b1;
    in_state      = ~FIPS_IN;
    g = 0;
    while (!out_valid_v[0] && g < 64) begin
      tick();
      g++;
    end
    check("bp_reach_done", 128'(out_valid_v[0]), 128'(1));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_out_valid", 128'(out_valid_v[0]), 128'(1));
      check("bp_out_state", out_state_a[0],       FIPS_OUT);
      check("bp_in_ready",  128'(in_ready_v[0]),  128'(0));
      @(posedge clk);
      #1;
      in_valid_v[0] = k[0];
      in_state      = {$urandom, $urandom, $urandom, $urandom};
    end
    // Release with in_valid still high: it must not be taken in DONE.
    in_valid_v[0] = 1'b1;
    out_ready     = 1'b1;
    tick();
    in_valid_v[0] = 1'b0;
    check("bp_idle_in_ready",  128'(in_ready_v[0]),  128'(1));
    check("bp_idle_out_valid", 128'(out_valid_v[0]), 128'(0));
    tick();
    check("bp_no_capture_busy", 128'(busy_v[0]), 128'(0));
    check("bp_queue_empty", 128'(exp_q.size()), 128'(0));

    // Reset during BUSY cycle 2
    send(0, FIPS_IN, 1'b0, FIPS_OUT, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("midrst_out_valid", 128'(out_valid_v[0]), 128'(0));
    check("midrst_in_ready",  128'(in_ready_v[0]),  128'(1));
    check("midrst_out_state", out_state_a[0],       128'(0));
    send(0, KNOWN_IN, 1'b0, KNOWN_OUT, 1'b0);
    wait_out(0, 4);
    drain();
    tick();

    // Back-to-back random states with in_valid held high
    for (int k = 0; k < 8; k++) begin
      st = {$urandom, $urandom, $urandom, $urandom};
      send(0, st, 1'b0, mix_ref(st), 1'b1);
    end
    in_valid_v[0] = 1'b0;
    drain();
    repeat (8) tick();
    check("final_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
